systolic_row_feeder: RTL and testbench
======================================

# systolic_row_feeder

Buffered, skewing feeder between the input FIFO and the west edge of the systolic array. It pops one element per cycle from the FIFO's producer port until a full `rows_p × kdim_p` operand tile is buffered. It then streams the tile into the array row lanes with the diagonal skew the PE grid requires: lane r is delayed r cycles. The block is single-buffered and alternates strictly between filling and draining.

## Interface
- `width_p`, 8, element width in bits
- `rows_p`, 4, number of array row lanes; must be ≥ 1
- `kdim_p`, 4, elements per row per tile (reduction depth); must be ≥ 1

- `clk_i`  input  1  sole clock; all state updates on its rising edge
- `reset_i`  input  1  asynchronous, active-high reset
- `valid_i`  input  1  FIFO holds an element
- `data_i`  input  `width_p`  FIFO head element
- `yumi_o`  output  1  pop strobe to FIFO; asserted only when `valid_i` is high
- `ready_i`  input  1  array accepts a beat this cycle
- `valid_o`  output  1  beat present on `data_o`
- `data_o`  output  `rows_p*width_p`  lane r at `[r*width_p +: width_p]`
- `lane_valid_o`  output  `rows_p`  bit r set when lane r carries a real element; otherwise lane data is zero
- `last_o`  output  1  final beat of the tile; qualified by `valid_o`

## Operation
- **States:** FILL and DRAIN. Reset state is FILL.
- **FILL:**
  - `yumi_o = valid_i`.
  - Each pop writes `data_i` into buf[row][k]. Fill order is row-major: index i maps to row = i / kdim_p, k = i % kdim_p.
  - The fill counter increments per pop.
  - On the pop with index `rows_p*kdim_p-1`, the counter clears and the state becomes DRAIN on the next edge.
- **DRAIN:**
  - `yumi_o = 0`.
  - `valid_o = 1`.
  - Beat counter t ranges over 0..B-1, where B = `rows_p+kdim_p-1`.
  - Lane r outputs buf[r][t-r] with `lane_valid_o[r]=1` when 0 ≤ t-r < `kdim_p`. Otherwise it outputs zero with `lane_valid_o[r]=0`.
  - `last_o = (t == B-1)`.
  - t advances only when `ready_i` is high. While `ready_i` is low, `data_o`, `lane_valid_o` and `last_o` hold stable.
  - When the beat with t = B-1 is accepted, t clears and the state becomes FILL.
- **Outputs:** decoded combinationally from state, t and the buffer. No combinational path exists from `ready_i` to any output. The only combinational input→output path is `valid_i` → `yumi_o`.
- **Widths:**
  - Fill counter: `$clog2(rows_p*kdim_p)` bits, minimum 1.
  - Beat counter: `$clog2(B)` bits, minimum 1.
  - Lane-index subtraction t-r is evaluated signed, or with an explicit t ≥ r guard; an unsigned wrap must never select an element.
- **Buffer:** plain flops, no reset required. Contents of a drained tile are never re-emitted.

## Timing
- **Reset values** (asynchronous assert, synchronous-safe deassert):
  - state = FILL; fill and beat counters = 0.
  - `valid_o` = 0, `last_o` = 0, `lane_valid_o` = 0, `data_o` = 0.
  - `yumi_o` is forced 0 while `reset_i` is high.
- **Reset mid-operation:**
  - A partial fill is discarded. Elements already popped are lost; this is the caller's responsibility.
  - A partial drain is abandoned. `valid_o` drops in the same cycle reset asserts.
- **Latency:** the last pop is at cycle c, and the first beat has `valid_o` high at cycle c+1.
- **Throughput:** with `valid_i` and `ready_i` held high, one tile takes `rows_p*kdim_p` + B cycles.
- **Gaps:** a FIFO gap (`valid_i` low) stalls the fill with no state change. `ready_i` low stalls the drain.
- **No overlap:** `yumi_o` and `valid_o` are never high in the same cycle.
- **Degenerate sizes:**
  - `rows_p=1`: no skew, B = `kdim_p`.
  - `kdim_p=1`: B = `rows_p`, one element per lane on the diagonal.

## Structure
- `systolic_pkg` holds `feeder_state_e` (FILL, DRAIN) and a `localparam`-style function for beat count B. Both are shared with the array controller that counts accumulation cycles.
- One sub-module is natural: `feeder_tile_buf`. It is a `rows_p × kdim_p` register file with a single write port, indexed by the fill counter, and exposes all entries flat for the lane muxes.
- Skew muxing and the FSM stay in the top module.

## Test plan
Unless noted, `rows_p=2`, `kdim_p=3`, `width_p=8`.

- **Basic tile:** push 1..6 with `ready_i` held high. Required beats:
  - t0: data {lane1=0, lane0=1}, `lane_valid_o`=01
  - t1: {4,2}, 11
  - t2: {5,3}, 11
  - t3: {6,0}, 10, with `last_o`=1
  - Then `yumi_o` resumes the next cycle.
- **Backpressure:** same tile with `ready_i` low on t1 for 3 cycles. The beat {4,2} is held for 4 cycles, then t2 through t3 proceed; still exactly 4 distinct beats.
- **FIFO gaps:** `valid_i` toggles 1,0,1,0… The six pops occur only on high cycles; `yumi_o` never rises while `valid_i` is low; output beats are the same as the basic tile.
- **Back-to-back tiles:** push 1..12 continuously. Two tiles come out, the second with lanes {0,7},{10,8},{11,9},{12,0}. No pops occur during either drain.
- **Async reset mid-drain:** assert `reset_i` during t2 between edges.
  - `valid_o` goes 0 immediately.
  - After release, state is FILL.
  - Pushing 21..26 yields {0,21},{24,22},{25,23},{26,0}.
- **Degenerate sizes:** `rows_p=1`, `kdim_p=1`. Push 9 and get a single beat with data 9, `lane_valid_o`=1, `last_o`=1, accepted on the first `ready_i`.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the systolic array west-edge feeder and
// the array controller.
//   feeder_state_e : feeder FSM states (fill the tile buffer / drain it skewed)
//   beat_count     : beats per skewed tile, rows + kdim - 1
//   cnt_width      : counter width for a count of n values, at least 1 bit
package systolic_pkg;

  typedef enum logic [0:0] {
    StFill,
    StDrain
  } feeder_state_e;

  function automatic int unsigned beat_count(input int unsigned rows, input int unsigned kdim);
    return rows + kdim - 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/feeder_tile_buf.sv
// Operand tile register file: rows_p x kdim_p entries, one write port,
// all entries exposed flat for the lane muxes. Entry index is row-major,
// so the fill counter addresses it directly. No reset: contents are always
// rewritten before they are read.
//   clk_i     : clock
//   we_i      : write enable
//   waddr_i   : entry index (row * kdim_p + k)
//   wdata_i   : element to write
//   entries_o : entry i at [i*width_p +: width_p]
module feeder_tile_buf
  import systolic_pkg::*;
#(
  parameter int unsigned width_p = 8,
  parameter int unsigned rows_p  = 4,
  parameter int unsigned kdim_p  = 4
) (
  input  logic                                   clk_i,
  input  logic                                   we_i,
  input  logic [cnt_width(rows_p*kdim_p)-1:0]    waddr_i,
  input  logic [width_p-1:0]                     wdata_i,
  output logic [rows_p*kdim_p*width_p-1:0]       entries_o
);

  localparam int unsigned Entries = rows_p * kdim_p;

  logic [width_p-1:0] mem_q [Entries];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  for (genvar i = 0; i < Entries; i++) begin : g_flat
    assign entries_o[i*width_p +: width_p] = mem_q[i];
  end

endmodule

// File: rtl/systolic_row_feeder.sv
// Buffered, skewing feeder from the input FIFO to the systolic array west edge.
// Pops a full rows_p x kdim_p tile, then streams it with lane r delayed r beats.
// Strictly alternates fill and drain (single buffer).
//   clk_i, reset_i : clock, asynchronous active-high reset
//   valid_i/data_i : FIFO head; yumi_o pops it
//   ready_i        : array accepts the beat on data_o this cycle
//   valid_o/data_o : beat, lane r at [r*width_p +: width_p]
//   lane_valid_o   : per-lane real-element flags (lane data is zero otherwise)
//   last_o         : final beat of the tile
module systolic_row_feeder
  import systolic_pkg::*;
#(
  parameter int unsigned width_p = 8,
  parameter int unsigned rows_p  = 4,
  parameter int unsigned kdim_p  = 4
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        valid_i,
  input  logic [width_p-1:0]          data_i,
  output logic                        yumi_o,
  input  logic                        ready_i,
  output logic                        valid_o,
  output logic [rows_p*width_p-1:0]   data_o,
  output logic [rows_p-1:0]           lane_valid_o,
  output logic                        last_o
);

  localparam int unsigned Total = rows_p * kdim_p;
  localparam int unsigned Beats = beat_count(rows_p, kdim_p);
  localparam int unsigned FillW = cnt_width(Total);
  localparam int unsigned BeatW = cnt_width(Beats);
  localparam logic [FillW-1:0] FillLast = FillW'(Total - 1);
  localparam logic [BeatW-1:0] BeatLast = BeatW'(Beats - 1);

  feeder_state_e            state_q;
  logic [FillW-1:0]         fill_q;
  logic [BeatW-1:0]         beat_q;
  logic [Total*width_p-1:0] entries;

  // reset_i gates the pop so no element is consumed while the block is held.
  assign yumi_o  = (state_q == StFill) && valid_i && !reset_i;
  assign valid_o = (state_q == StDrain);
  assign last_o  = valid_o && (beat_q == BeatLast);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StFill;
      fill_q  <= '0;
      beat_q  <= '0;
    end else begin
      unique case (state_q)
        StFill: begin
          if (valid_i) begin
            if (fill_q == FillLast) begin
              fill_q  <= '0;
              state_q <= StDrain;
            end else begin
              fill_q <= fill_q + 1'b1;
            end
          end
        end
        StDrain: begin
          if (ready_i) begin
            if (beat_q == BeatLast) begin
              beat_q  <= '0;
              state_q <= StFill;
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end
        end
        default: state_q <= StFill;
      endcase
    end
  end

  feeder_tile_buf #(
    .width_p (width_p),
    .rows_p  (rows_p),
    .kdim_p  (kdim_p)
  ) u_tile_buf (
    .clk_i     (clk_i),
    .we_i      (yumi_o),
    .waddr_i   (fill_q),
    .wdata_i   (data_i),
    .entries_o (entries)
  );

  // Skew mux: lane r shows k = t - r. Signed difference so lanes not yet
  // started (t < r) never alias onto a real element.
  always_comb begin
    int d;
    d            = 0;
    data_o       = '0;
    lane_valid_o = '0;
    if (state_q == StDrain) begin
      for (int r = 0; r < int'(rows_p); r++) begin
        d = int'(beat_q) - r;
        if (d >= 0 && d < int'(kdim_p)) begin
          data_o[r*width_p +: width_p] = entries[(r*int'(kdim_p) + d)*int'(width_p) +: width_p];
          lane_valid_o[r] = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_systolic_row_feeder.sv
module tb_systolic_row_feeder;

  localparam int R = 2;
  localparam int K = 3;
  localparam int N = R * K;
  localparam int B = R + K - 1;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        valid_i;
  logic [7:0]  data_i;
  logic        yumi_o;
  logic        ready_i;
  logic        valid_o;
  logic [15:0] data_o;
  logic [1:0]  lane_valid_o;
  logic        last_o;

  logic        d_valid_i;
  logic [7:0]  d_data_i;
  logic        d_yumi_o;
  logic        d_ready_i;
  logic        d_valid_o;
  logic [7:0]  d_data_o;
  logic [0:0]  d_lane_valid_o;
  logic        d_last_o;

  always #5 clk = ~clk;

  systolic_row_feeder #(
    .width_p (8),
    .rows_p  (R),
    .kdim_p  (K)
  ) u_dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .valid_i      (valid_i),
    .data_i       (data_i),
    .yumi_o       (yumi_o),
    .ready_i      (ready_i),
    .valid_o      (valid_o),
    .data_o       (data_o),
    .lane_valid_o (lane_valid_o),
    .last_o       (last_o)
  );

  systolic_row_feeder #(
    .width_p (8),
    .rows_p  (1),
    .kdim_p  (1)
  ) u_dut_1x1 (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .valid_i      (d_valid_i),
    .data_i       (d_data_i),
    .yumi_o       (d_yumi_o),
    .ready_i      (d_ready_i),
    .valid_o      (d_valid_o),
    .data_o       (d_data_o),
    .lane_valid_o (d_lane_valid_o),
    .last_o       (d_last_o)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Tile-level model: collect a tile, then describe beat t lane r as
  // element (r, t-r) of the collected tile when that index exists.
  logic [7:0]  m_tile [N];
  int          m_cnt   = 0;
  int          m_t     = 0;
  bit          m_drain = 1'b0;
  bit          cmp_en  = 1'b0;
  int          vcyc    = 0;
  logic [18:0] log_q [$];
  logic [18:0] exp_q [$];

  always @(negedge clk) begin
    if (cmp_en) begin
      if (reset_i) begin
        check("rst_valid_o", valid_o, 0);
        check("rst_yumi_o", yumi_o, 0);
        check("rst_data_o", data_o, 0);
        check("rst_lane_valid_o", lane_valid_o, 0);
        check("rst_last_o", last_o, 0);
        m_drain = 1'b0;
        m_cnt   = 0;
        m_t     = 0;
      end else if (!m_drain) begin
        check("fill_yumi_o", yumi_o, valid_i);
        check("fill_valid_o", valid_o, 0);
        if (valid_i) begin
          m_tile[m_cnt] = data_i;
          m_cnt++;
          if (m_cnt == N) begin
            m_drain = 1'b1;
            m_cnt   = 0;
            m_t     = 0;
          end
        end
      end else begin
        logic [15:0] ed;
        logic [1:0]  elv;
        ed  = '0;
        elv = '0;
        for (int r = 0; r < R; r++) begin
          int k;
          k = m_t - r;
          if (k >= 0 && k < K) begin
            ed[r*8 +: 8] = m_tile[r*K + k];
            elv[r]       = 1'b1;
          end
        end
        check("drain_yumi_o", yumi_o, 0);
        check("drain_valid_o", valid_o, 1);
        check("drain_data_o", data_o, ed);
        check("drain_lane_valid_o", lane_valid_o, elv);
        check("drain_last_o", last_o, (m_t == B - 1));
        vcyc++;
        if (ready_i) begin
          log_q.push_back({last_o, lane_valid_o, data_o});
          if (m_t == B - 1) m_drain = 1'b0;
          else m_t++;
        end
      end
    end
  end

  function automatic logic [18:0] pk(input int l1, input int l0, input logic [1:0] lv,
                                     input logic last);
    logic [7:0] a;
    logic [7:0] b;
    a = 8'(l1);
    b = 8'(l0);
    return {last, lv, a, b};
  endfunction

  // Drives elements base..base+n-1 through the FIFO handshake and ready_i.
  // gaps: valid_i only on even cycles. stall_len: ready_i low for that many
  // cycles while beat t=1 is shown. abort_t >= 0: return once beat abort_t shows.
  task automatic run_test(input int n, input int base, input bit gaps, input int stall_len,
                          input int abort_t, input int exp_beats);
    int  idx     = 0;
    int  cyc     = 0;
    int  stalled = 0;
    bit  done    = 1'b0;
    log_q.delete();
    vcyc = 0;
    while (!done && cyc < 300) begin
      @(posedge clk); #1;
      if (abort_t >= 0 && m_drain && m_t == abort_t) begin
        done = 1'b1;
      end else if (exp_beats > 0 && log_q.size() >= exp_beats && !m_drain) begin
        done = 1'b1;
      end else begin
        valid_i = (idx < n) && (!gaps || (cyc % 2 == 0));
        data_i  = valid_i ? 8'(base + idx) : 8'h00;
        ready_i = !(m_drain && m_t == 1 && stalled < stall_len);
        if (!ready_i) stalled++;
        @(negedge clk);
        if (valid_i && yumi_o) idx++;
        cyc++;
      end
    end
    valid_i = 1'b0;
    check("run_done", done, 1);
  endtask

  task automatic check_log(input string name);
    check({name, "_beat_count"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [18:0] got;
      got = (i < log_q.size()) ? log_q[i] : 19'h0;
      check($sformatf("%s_beat%0d", name, i), got, exp_q[i]);
    end
  endtask

  task automatic push_tile1();
    exp_q.push_back(pk(0, 1, 2'b01, 1'b0));
    exp_q.push_back(pk(4, 2, 2'b11, 1'b0));
    exp_q.push_back(pk(5, 3, 2'b11, 1'b0));
    exp_q.push_back(pk(6, 0, 2'b10, 1'b1));
  endtask

  initial begin
    reset_i   = 1'b1;
    valid_i   = 1'b1;
    data_i    = 8'h55;
    ready_i   = 1'b1;
    d_valid_i = 1'b0;
    d_data_i  = 8'h00;
    d_ready_i = 1'b0;
    cmp_en    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_1x1_yumi", d_yumi_o, 0);
    check("rst_1x1_valid", d_valid_o, 0);
    reset_i = 1'b0;
    valid_i = 1'b0;

    // Basic tile
    exp_q.delete();
    push_tile1();
    run_test(6, 1, 1'b0, 0, -1, 4);
    check_log("basic");
    check("basic_valid_cycles", vcyc, 4);

    // Backpressure on t1
    run_test(6, 1, 1'b0, 3, -1, 4);
    check_log("bp");
    check("bp_valid_cycles", vcyc, 7);

    // FIFO gaps
    run_test(6, 1, 1'b1, 0, -1, 4);
    check_log("gaps");

    // Back-to-back tiles
    exp_q.push_back(pk(0, 7, 2'b01, 1'b0));
    exp_q.push_back(pk(10, 8, 2'b11, 1'b0));
    exp_q.push_back(pk(11, 9, 2'b11, 1'b0));
    exp_q.push_back(pk(12, 0, 2'b10, 1'b1));
    run_test(12, 1, 1'b0, 0, -1, 8);
    check_log("b2b");
    check("b2b_valid_cycles", vcyc, 8);

    // Async reset mid-drain
    run_test(6, 1, 1'b0, 0, 2, 0);
    valid_i = 1'b1;
    data_i  = 8'h77;
    #2;
    reset_i = 1'b1;
    #1;
    check("async_valid_drop", valid_o, 0);
    check("async_yumi_forced", yumi_o, 0);
    @(posedge clk); #1;
    reset_i = 1'b0;
    valid_i = 1'b0;
    exp_q.delete();
    exp_q.push_back(pk(0, 21, 2'b01, 1'b0));
    exp_q.push_back(pk(24, 22, 2'b11, 1'b0));
    exp_q.push_back(pk(25, 23, 2'b11, 1'b0));
    exp_q.push_back(pk(26, 0, 2'b10, 1'b1));
    run_test(6, 21, 1'b0, 0, -1, 4);
    check_log("post_rst");

    // Degenerate 1x1 tile
    @(posedge clk); #1;
    d_valid_i = 1'b1;
    d_data_i  = 8'd9;
    d_ready_i = 1'b0;
    @(negedge clk);
    check("deg_pop", d_yumi_o, 1);
    check("deg_fill_valid_o", d_valid_o, 0);
    @(posedge clk); #1;
    d_valid_i = 1'b0;
    @(negedge clk);
    check("deg_valid_o", d_valid_o, 1);
    check("deg_data_o", d_data_o, 9);
    check("deg_lane_valid", d_lane_valid_o, 1);
    check("deg_last_o", d_last_o, 1);
    @(posedge clk); #1;
    d_valid_i = 1'b1;
    d_data_i  = 8'd5;
    @(negedge clk);
    check("deg_hold_valid", d_valid_o, 1);
    check("deg_hold_data", d_data_o, 9);
    check("deg_no_pop_in_drain", d_yumi_o, 0);
    @(posedge clk); #1;
    d_ready_i = 1'b1;
    @(negedge clk);
    check("deg_accept_valid", d_valid_o, 1);
    @(posedge clk); #1;
    d_ready_i = 1'b0;
    @(negedge clk);
    check("deg_after_valid", d_valid_o, 0);
    check("deg_after_pop", d_yumi_o, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
